// File: rtl/gpu_axil_pkg.sv
// Shared types and helpers for the GPU_LITE AXI4-Lite register slave.
package gpu_axil_pkg;

    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = 4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    // Merge new data into old data byte by byte under the strobe mask.
    function automatic logic [AXIL_DATA_W-1:0] apply_strb(
        input logic [AXIL_DATA_W-1:0] old_val,
        input logic [AXIL_DATA_W-1:0] new_val,
        input logic [AXIL_STRB_W-1:0] strb
    );
        logic [AXIL_DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < AXIL_STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gpu_axil_hold.sv
// One-entry valid/ready holding register; o_data/o_avail show the held entry
// or, while empty, the entry being offered this cycle.
module gpu_axil_hold #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_clr,
    output logic         o_avail,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;
    logic         w_load;

    assign o_ready = !r_full;
    assign w_load  = i_valid && !r_full;
    assign o_avail = r_full || w_load;
    assign o_data  = r_full ? r_data : i_data;

    // Entry fills on a handshake and empties only when the owner releases it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end else if (w_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/gpu_axil_reg_slave.sv
// AXI4-Lite register slave for the GPU_LITE ports (NUM_REGS x 32-bit registers).
// Define GPU_AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR.
module gpu_axil_reg_slave
    import gpu_axil_pkg::*;
#(
    parameter int          ADDR_W   = 4,
    parameter int          NUM_REGS = 4,
    parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int WB_W  = AXIL_DATA_W + AXIL_STRB_W;

    wr_state_t r_wr_state, w_wr_state_nxt;
    rd_state_t r_rd_state, w_rd_state_nxt;

    logic [AXIL_DATA_W-1:0] r_regs [NUM_REGS];
    logic                   r_bvalid, r_rvalid;
    resp_t                  r_bresp, r_rresp;
    logic [AXIL_DATA_W-1:0] r_rdata;
    logic [NUM_REGS-1:0]    r_wr_pulse;

    logic                   w_aw_avail, w_w_avail, w_ar_avail;
    logic [ADDR_W-1:0]      w_aw_addr, w_ar_addr;
    logic [WB_W-1:0]        w_w_bundle;
    logic [AXIL_DATA_W-1:0] w_wdata, w_rd_data;
    logic [AXIL_STRB_W-1:0] w_wstrb;
    logic [IDX_W-1:0]       w_wr_idx, w_rd_idx;
    logic [NUM_REGS-1:0]    w_wr_sel, w_rd_sel;
    logic                   w_wr_in_range, w_rd_in_range;
    logic                   w_wr_commit, w_rd_go, w_b_hs, w_r_hs;
    resp_t                  w_wr_resp, w_rd_resp;
    logic                   w_unused_ok;

    gpu_axil_hold #(.W(ADDR_W)) u_aw_hold (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_valid (S_AXI_AWVALID),
        .o_ready (S_AXI_AWREADY),
        .i_data  (S_AXI_AWADDR),
        .i_clr   (w_b_hs),
        .o_avail (w_aw_avail),
        .o_data  (w_aw_addr)
    );

    gpu_axil_hold #(.W(WB_W)) u_w_hold (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_valid (S_AXI_WVALID),
        .o_ready (S_AXI_WREADY),
        .i_data  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .i_clr   (w_b_hs),
        .o_avail (w_w_avail),
        .o_data  (w_w_bundle)
    );

    gpu_axil_hold #(.W(ADDR_W)) u_ar_hold (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_valid (S_AXI_ARVALID),
        .o_ready (S_AXI_ARREADY),
        .i_data  (S_AXI_ARADDR),
        .i_clr   (w_r_hs),
        .o_avail (w_ar_avail),
        .o_data  (w_ar_addr)
    );

    assign w_wdata  = w_w_bundle[AXIL_DATA_W-1:0];
    assign w_wstrb  = w_w_bundle[WB_W-1:AXIL_DATA_W];
    assign w_wr_idx = w_aw_addr[ADDR_W-1:2];
    assign w_rd_idx = w_ar_addr[ADDR_W-1:2];
    assign w_b_hs   = r_bvalid && S_AXI_BREADY;
    assign w_r_hs   = r_rvalid && S_AXI_RREADY;

    // Both holds full (or filling) while idle means the write commits at this edge.
    assign w_wr_commit = (r_wr_state == WR_IDLE) && w_aw_avail && w_w_avail;
    assign w_rd_go     = (r_rd_state == RD_IDLE) && w_ar_avail;

    // One-hot register decode and read-data mux; an all-zero select is out of range.
    always_comb begin
        w_wr_sel  = '0;
        w_rd_sel  = '0;
        w_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            w_wr_sel[k] = (32'(w_wr_idx) == $unsigned(k));
            w_rd_sel[k] = (32'(w_rd_idx) == $unsigned(k));
            w_rd_data   = w_rd_data | (r_regs[k] & {AXIL_DATA_W{w_rd_sel[k]}});
        end
    end

    assign w_wr_in_range = |w_wr_sel;
    assign w_rd_in_range = |w_rd_sel;

`ifdef GPU_AXIL_SLVERR_EN
    assign w_wr_resp = w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
    assign w_rd_resp = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
`else
    assign w_wr_resp = RESP_OKAY;
    assign w_rd_resp = RESP_OKAY;
`endif

    // FSM state registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    // Write FSM next state.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_wr_commit) w_wr_state_nxt = WR_RESP;
                else             w_wr_state_nxt = WR_IDLE;
            end
            WR_RESP: begin
                if (w_b_hs) w_wr_state_nxt = WR_IDLE;
                else        w_wr_state_nxt = WR_RESP;
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    // Read FSM next state.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_rd_go) w_rd_state_nxt = RD_RESP;
                else         w_rd_state_nxt = RD_IDLE;
            end
            RD_RESP: begin
                if (w_r_hs) w_rd_state_nxt = RD_IDLE;
                else        w_rd_state_nxt = RD_RESP;
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // Register array; out-of-range commits have an empty select and change nothing.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RST_VAL;
        end else if (w_wr_commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_wr_sel[k]) r_regs[k] <= apply_strb(r_regs[k], w_wdata, w_wstrb);
            end
        end
    end

    // Write response and per-register write pulse.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_wr_commit ? w_wr_sel : '0;
            if (w_wr_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_resp;
            end else if (w_b_hs) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read response; RDATA samples the pre-write register value on a shared edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_rd_go) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_o[32*k +: 32] = r_regs[k];
    end

    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;
    assign wr_pulse_o   = r_wr_pulse;

    assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_aw_addr[1:0], w_ar_addr[1:0],
                           w_rd_in_range, w_wr_in_range};

endmodule
